host_rx_reader: RTL and testbench

Host-side reader for the network-to-host CDC FIFO (77-bit words, clk_host domain). Pops words from the async FIFO read port and validates frame framing (sop/eop/keep/error bits). Presents each word on a registered valid/ready stream toward the host logic. A 2-entry output buffer with read credits sustains one word per cycle under backpressure.

---
 rtl/host_rx_reader_if.sv | 27 ++
 rtl/host_rx_reader.sv | 150 +++++++++++++++
 tb/tb_host_rx_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_rx_reader_if.sv
// host_rx_reader_if: FIFO read port and host-facing word stream of the host RX reader.
// master = reader side (pops FIFO, drives stream), slave = FIFO/host side.
// Purely structural; no logic lives here.
interface host_rx_reader_if #(
  parameter int WIDTH = 77
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  logic [7:0]       m_keep;
  logic             m_sop;
  logic             m_eop;
  logic             m_err;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_keep, m_sop, m_eop, m_err
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_keep, m_sop, m_eop, m_err
  );
endinterface

// File: rtl/host_rx_reader.sv
// host_rx_reader: pops the host-side CDC FIFO, validates sop/eop/keep/error framing, forwards words.
// Latency: fifo_rd_en in cycle N -> word captured end of N+1 -> m_valid in N+2; 1 word/cycle sustained.
// Backpressure: 2-entry output buffer with read credits; optional HOST_RX_STATS_EN adds frame/drop counters.
module host_rx_reader #(
  parameter int WIDTH = 77
`ifdef HOST_RX_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk_host,
  input  logic             rst,
  host_rx_reader_if.master bus,
  output logic             proto_err
`ifdef HOST_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
    logic        err;
  } ent_t;

  state_t           state_q, state_d;
  logic             inflight_q;
  logic [1:0]       count_q;
  ent_t             head_q, tail_q;
  ent_t             new_ent;
  logic [WIDTH-1:0] word;
  logic             w_sop, w_eop;
  logic [2:0]       w_code;
  logic [7:0]       w_keep;
  logic             store, drop, trunc, word_err;
  logic             pop;
  logic [2:0]       occ;

  assign word   = bus.fifo_dout;
  assign w_sop  = word[76];
  assign w_eop  = word[75];
  assign w_code = word[74:72];
  assign w_keep = word[71:64];

  // Credit check counts a word leaving the buffer this cycle as a returned slot,
  // so a steady stream keeps one word buffered and one in flight without bubbles.
  assign pop            = bus.m_valid & bus.m_ready;
  assign occ            = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign bus.fifo_rd_en = ~bus.fifo_empty & (occ < 3'd2);

  // Track the pop issued last cycle: its word is on fifo_dout now.
  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= bus.fifo_rd_en;
  end

  // Frame FSM state register.
  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: any stored word (sop in IDLE, anything in a frame) lets eop decide.
  always_comb begin
    state_d = state_q;
    if (inflight_q && (state_q == IN_FRAME || w_sop)) begin
      state_d = w_eop ? IDLE : IN_FRAME;
    end
  end

  // Per-word decode: keep or discard, and whether the forwarded word carries an error.
  always_comb begin
    store    = 1'b0;
    drop     = 1'b0;
    trunc    = 1'b0;
    word_err = 1'b0;
    if (inflight_q) begin
      store    = w_sop | (state_q == IN_FRAME);
      drop     = ~store;
      trunc    = w_sop & (state_q == IN_FRAME);
      word_err = trunc | (w_code != 3'd0) | (~w_eop & (w_keep != 8'hFF)) |
                 (w_eop & (w_keep == 8'h00));
    end
  end

  assign new_ent = {word[63:0], w_keep, w_sop, w_eop, word_err};

  // Two-slot output buffer; head register drives the stream directly.
  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({store, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= new_ent;
          else                 tail_q <= new_ent;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= new_ent;
          end else begin
            head_q <= tail_q;
            tail_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = head_q.data;
  assign bus.m_keep  = head_q.keep;
  assign bus.m_sop   = head_q.sop;
  assign bus.m_eop   = head_q.eop;
  assign bus.m_err   = head_q.err;

  // One pulse per discarded word or forwarded word carrying an error.
  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else     proto_err <= drop | (store & word_err);
  end

`ifdef HOST_RX_STATS_EN
  // Saturating statistics: completed frames and discarded words.
  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (store && w_eop && (frame_cnt != {CNT_W{1'b1}})) frame_cnt <= frame_cnt + 1'b1;
      if (drop && (drop_cnt != {CNT_W{1'b1}}))            drop_cnt  <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_host_rx_reader.sv
// tb_host_rx_reader: randomized and directed stimulus for host_rx_reader.
// A queue-based FIFO source and a frame-rule scoreboard predict every forwarded word and proto_err pulse.
// Stream words are compared on every accept; held data is compared while the host stalls.
module tb_host_rx_reader;
  localparam int CNT_W = 32;

  logic clk_host = 1'b0;
  logic rst;
  logic proto_err;
`ifdef HOST_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt, drop_cnt;
`endif

  host_rx_reader_if #(.WIDTH(77)) bus ();

  host_rx_reader dut (
    .clk_host (clk_host),
    .rst      (rst),
    .bus      (bus),
    .proto_err(proto_err)
`ifdef HOST_RX_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk_host = ~clk_host;

  int n_vec = 0;
  int n_err = 0;

  logic [76:0] srcq[$];
  logic [74:0] expq[$];
  logic        pend_v = 1'b0;
  logic [76:0] pend_w = '0;
  int          stall_pct = 0;
  int          rdy_pct = 100;
  int          pop_cnt = 0, acc_cnt = 0, perr_cnt = 0, erracc_cnt = 0;

  logic             s_v[3];
  logic [76:0]      s_w[3];
  logic             in_frame;
  logic [CNT_W-1:0] mf, md;
  logic             hold_v;
  logic [74:0]      hold_w;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [76:0] mk(input logic sop, input logic eop, input logic [2:0] code,
                                     input logic [7:0] keep, input logic [63:0] data);
    return {sop, eop, code, keep, data};
  endfunction

  function automatic logic [76:0] rnd77();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[76:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // FIFO source and host ready, updated just after each rising edge.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_dout  = '0;
    forever begin
      @(posedge clk_host);
      #1;
      bus.fifo_dout  = pend_v ? pend_w : rnd77();
      bus.fifo_empty = (srcq.size() == 0) || ($urandom_range(99) < stall_pct);
      bus.m_ready    = ($urandom_range(99) < rdy_pct);
    end
  end

  // Compare process: a popped word is judged two cycles later, when its proto_err is due.
  always @(negedge clk_host) begin : mon
    logic [74:0] got;
    logic [76:0] w;
    logic        perr_exp, e, sop, eop;
    logic [7:0]  keep;
    got = {bus.m_data, bus.m_keep, bus.m_sop, bus.m_eop, bus.m_err};
    if (rst) begin
      chk("reset_m_valid", bus.m_valid, 1'b0);
      chk("reset_proto_err", proto_err, 1'b0);
      for (int k = 0; k < 3; k++) s_v[k] = 1'b0;
      expq.delete();
      in_frame = 1'b0;
      mf       = '0;
      md       = '0;
      pend_v   = 1'b0;
      hold_v   = 1'b0;
    end else begin
      s_v[2] = s_v[1]; s_w[2] = s_w[1];
      s_v[1] = s_v[0]; s_w[1] = s_w[0];
      s_v[0] = 1'b0;
      pend_v = 1'b0;
      if (bus.fifo_rd_en) begin
        pop_cnt++;
        chk("pop_while_empty", bus.fifo_empty, 1'b0);
        if (srcq.size() > 0) begin
          w = srcq.pop_front();
          s_v[0] = 1'b1; s_w[0] = w;
          pend_v = 1'b1; pend_w = w;
        end
      end
      perr_exp = 1'b0;
      if (s_v[2]) begin
        w    = s_w[2];
        sop  = w[76];
        eop  = w[75];
        keep = w[71:64];
        e    = (w[74:72] != 3'd0) || (!eop && keep != 8'hFF) || (eop && keep == 8'h00);
        if (!in_frame && !sop) begin
          perr_exp = 1'b1;
          if (md != {CNT_W{1'b1}}) md = md + 1'b1;
        end else begin
          if (in_frame && sop) e = 1'b1;
          expq.push_back({w[63:0], keep, sop, eop, e});
          perr_exp = e;
          if (eop) begin
            in_frame = 1'b0;
            if (mf != {CNT_W{1'b1}}) mf = mf + 1'b1;
          end else begin
            in_frame = 1'b1;
          end
        end
      end
      chk("proto_err", proto_err, perr_exp);
      if (proto_err) perr_cnt++;
`ifdef HOST_RX_STATS_EN
      chk("frame_cnt", frame_cnt, mf);
      chk("drop_cnt", drop_cnt, md);
`endif
      if (hold_v) begin
        chk("hold_valid", bus.m_valid, 1'b1);
        chk("hold_data", got, hold_w);
      end
      if (bus.m_valid && bus.m_ready) begin
        acc_cnt++;
        if (bus.m_err) erracc_cnt++;
        if (expq.size() == 0) chk("word_unexpected", bus.m_valid, 1'b0);
        else                  chk("word", got, expq.pop_front());
      end
      hold_v = bus.m_valid && !bus.m_ready;
      hold_w = got;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_host);
      #2;
    end
  endtask

  task automatic wait_acc(input int target, input int bound, input string nm);
    int i;
    i = 0;
    while (acc_cnt < target && i < bound) begin
      cyc(1);
      i++;
    end
    chk(nm, acc_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    srcq.delete();
    #1;
    chk("reset_async_m_valid", bus.m_valid, 1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(1);
  endtask

  // Random frame generator: lengths 1-5 with occasional framing, code and keep corruption.
  int g_len = 0, g_pos = 0;
  task automatic gen_word();
    logic        sop, eop;
    logic [2:0]  code;
    logic [7:0]  keep;
    int          r;
    if (g_pos == 0) g_len = $urandom_range(1, 5);
    sop  = (g_pos == 0);
    eop  = (g_pos == g_len - 1);
    keep = eop ? 8'($urandom_range(1, 255)) : 8'hFF;
    code = 3'd0;
    r = $urandom_range(99);
    if (r < 5)        sop  = ~sop;
    else if (r < 8)   code = 3'($urandom_range(1, 7));
    else if (r < 11)  keep = eop ? 8'h00 : 8'($urandom_range(0, 254));
    srcq.push_back(mk(sop, eop, code, keep, rnd64()));
    g_pos = eop ? 0 : g_pos + 1;
  endtask

  initial begin : stim
    int i, n, first, last, lat, p0, a0, e0, r0;
    logic sopf, eopl;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // Reset values after release with an empty FIFO.
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, 64'h0);
    chk("rst_m_keep", bus.m_keep, 8'h0);
    chk("rst_flags", {bus.m_sop, bus.m_eop, bus.m_err}, 3'b000);
    chk("rst_rd_en", bus.fifo_rd_en, 1'b0);

    // Single clean word: latency and contents.
    srcq.push_back(mk(1'b1, 1'b1, 3'd0, 8'hFF, 64'h0123456789ABCDEF));
    i = 0;
    while (!bus.fifo_rd_en && i < 10) begin cyc(1); i++; end
    chk("t1_pop_issued", bus.fifo_rd_en, 1'b1);
    lat = 0;
    while (!bus.m_valid && lat < 10) begin cyc(1); lat++; end
    chk("t1_latency", lat, 2);
    chk("t1_m_data", bus.m_data, 64'h0123456789ABCDEF);
    chk("t1_m_err", bus.m_err, 1'b0);
`ifdef HOST_RX_STATS_EN
    chk("t1_frame_cnt", frame_cnt, 1);
`endif
    cyc(2);

    // Four-word frame at full rate: no bubbles.
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b1, 3'd0, 8'h0F, rnd64()));
    first = -1; last = -1; n = 0; sopf = 1'b0; eopl = 1'b0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      cyc(1);
      if (bus.m_valid && bus.m_ready) begin
        if (first < 0) begin first = k; sopf = bus.m_sop; end
        last = k; eopl = bus.m_eop; n++;
      end
    end
    chk("t2_words", n, 4);
    chk("t2_no_bubbles", last - first, 3);
    chk("t2_sop_first", sopf, 1'b1);
    chk("t2_eop_last", eopl, 1'b1);
    cyc(2);

    // Host stalls with six words queued: exactly two pops, then in-order drain.
    rdy_pct = 0;
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    for (int k = 0; k < 4; k++) srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, rnd64()));
    p0 = pop_cnt;
    cyc(10);
    chk("t3_pops_under_stall", pop_cnt - p0, 2);
    chk("t3_left_in_fifo", srcq.size(), 4);
    a0 = acc_cnt;
    rdy_pct = 100;
    wait_acc(a0 + 6, 40, "t3_delivered");

    // Two stray non-sop words in IDLE, then a clean frame.
    do_reset();
    e0 = perr_cnt; a0 = acc_cnt; r0 = erracc_cnt;
    srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, rnd64()));
    wait_acc(a0 + 2, 30, "t4_delivered");
    cyc(3);
    chk("t4_proto_err_pulses", perr_cnt - e0, 2);
    chk("t4_clean_frame", erracc_cnt - r0, 0);
`ifdef HOST_RX_STATS_EN
    chk("t4_drop_cnt", drop_cnt, 2);
`endif

    // sop in the middle of a frame: flagged, forwarded, closes on its eop.
    do_reset();
    e0 = perr_cnt; a0 = acc_cnt; r0 = erracc_cnt;
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b1, 1'b1, 3'd0, 8'hFF, rnd64()));
    wait_acc(a0 + 3, 30, "t5_delivered");
    cyc(3);
    chk("t5_proto_err_pulses", perr_cnt - e0, 1);
    chk("t5_err_words", erracc_cnt - r0, 1);
`ifdef HOST_RX_STATS_EN
    chk("t5_frame_cnt", frame_cnt, 1);
`endif

    // Reset with two buffered words, then reset mid-stream with a word in flight.
    rdy_pct = 0;
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    srcq.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, rnd64()));
    cyc(6);
    chk("t6_buffered_valid", bus.m_valid, 1'b1);
    do_reset();
    rdy_pct = 100;
    srcq.push_back(mk(1'b1, 1'b0, 3'd0, 8'hFF, rnd64()));
    for (int k = 0; k < 5; k++) srcq.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, rnd64()));
    cyc(3);
    chk("t6_stream_in_flight", bus.fifo_rd_en, 1'b1);
    do_reset();
    a0 = acc_cnt; r0 = erracc_cnt;
    srcq.push_back(mk(1'b1, 1'b1, 3'd0, 8'h3F, rnd64()));
    wait_acc(a0 + 1, 20, "t6_after_reset");
    chk("t6_after_reset_clean", erracc_cnt - r0, 0);

    // Randomized traffic with stalls on both sides and one mid-run reset.
    stall_pct = 20;
    rdy_pct   = 70;
    g_pos     = 0;
    for (int k = 0; k < 3000; k++) begin
      while (srcq.size() < 6) gen_word();
      if (k == 1500) begin
        do_reset();
        g_pos = 0;
      end
      cyc(1);
    end
    while (g_pos != 0) gen_word();
    stall_pct = 0;
    rdy_pct   = 100;
    i = 0;
    while ((srcq.size() != 0 || expq.size() != 0 || bus.m_valid) && i < 200) begin
      cyc(1);
      i++;
    end
    cyc(4);
    chk("drain_fifo_empty", srcq.size(), 0);
    chk("drain_model_empty", expq.size(), 0);
    chk("drain_m_valid", bus.m_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, got %0t expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "time limit");
  end

endmodule
